// File: rtl/led_pattern_mux.sv
// LED pattern source: synchronised switches select pass/chase/count/blink, stepped by a prescaled tick.
// Optional build macro LED_BOUNCE_EN turns the chaser into a ping-pong pattern.
module led_pattern_mux #(
  parameter int unsigned TICK_DIV = 12_500_000,
  parameter int unsigned WIDTH    = 8
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic [WIDTH-1:0] sw_in,
  input  logic [1:0]       mode_in,
  output logic             tick_out,
  output logic [WIDTH-1:0] y_out
);

  localparam int unsigned   CW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    MODE_PASS  = 2'd0,
    MODE_CHASE = 2'd1,
    MODE_COUNT = 2'd2,
    MODE_BLINK = 2'd3
  } mode_e;

  logic [WIDTH-1:0] sw_meta_q;
  logic [WIDTH-1:0] sw_s_q;
  logic [1:0]       mode_meta_q;
  mode_e            mode_s_q;
  mode_e            mode_q;
  logic [CW-1:0]    cnt_q;
  logic [CW-1:0]    cnt_d;
  logic             tick_q;
  logic [WIDTH-1:0] y_q;
  logic [WIDTH-1:0] y_d;
  logic             phase_q;
  logic             phase_d;
  logic             step_s;
  logic             chg_s;
`ifdef LED_BOUNCE_EN
  logic             dir_q;
  logic             dir_d;
`endif

  // Two-flop synchronisers for the asynchronous switch inputs
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      sw_meta_q   <= '0;
      sw_s_q      <= '0;
      mode_meta_q <= 2'd0;
      mode_s_q    <= MODE_PASS;
    end else begin
      sw_meta_q   <= sw_in;
      sw_s_q      <= sw_meta_q;
      mode_meta_q <= mode_in;
      mode_s_q    <= mode_e'(mode_meta_q);
    end
  end

  // Prescaler, mode change handling and per-mode pattern update
  always_comb begin
    step_s  = (cnt_q == CNT_LAST);
    chg_s   = (mode_s_q != mode_q);
    cnt_d   = step_s ? '0 : cnt_q + CW'(1'b1);
    y_d     = y_q;
    phase_d = phase_q;
`ifdef LED_BOUNCE_EN
    dir_d   = dir_q;
`endif
    if (chg_s) begin
      // A mode change wins over a coincident tick: restart the prescaler, load the new init value
      cnt_d = '0;
      case (mode_s_q)
        MODE_PASS:  y_d = sw_s_q;
        MODE_CHASE: begin
          y_d = {{(WIDTH-1){1'b0}}, 1'b1};
`ifdef LED_BOUNCE_EN
          dir_d = 1'b0;
`endif
        end
        MODE_COUNT: y_d = '0;
        MODE_BLINK: begin
          y_d     = sw_s_q;
          phase_d = 1'b1;
        end
        default:    y_d = '0;
      endcase
    end else begin
      case (mode_q)
        MODE_PASS:  y_d = sw_s_q;
        MODE_CHASE: begin
          if (step_s) begin
`ifdef LED_BOUNCE_EN
            // dir_q=0 walks towards the MSB, dir_q=1 back towards the LSB
            if (!dir_q) begin
              if (y_q[WIDTH-1]) begin
                y_d   = y_q >> 1'b1;
                dir_d = 1'b1;
              end else begin
                y_d   = y_q << 1'b1;
              end
            end else begin
              if (y_q[0]) begin
                y_d   = y_q << 1'b1;
                dir_d = 1'b0;
              end else begin
                y_d   = y_q >> 1'b1;
              end
            end
`else
            y_d = {y_q[WIDTH-2:0], y_q[WIDTH-1]};
`endif
          end else begin
            y_d = y_q;
          end
        end
        MODE_COUNT: begin
          if (step_s) begin
            y_d = y_q + WIDTH'(1'b1);
          end else begin
            y_d = y_q;
          end
        end
        MODE_BLINK: begin
          if (step_s) begin
            phase_d = ~phase_q;
          end else begin
            phase_d = phase_q;
          end
          y_d = phase_d ? sw_s_q : '0;
        end
        default:    y_d = '0;
      endcase
    end
  end

  // Pattern state registers
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      mode_q  <= MODE_PASS;
      cnt_q   <= '0;
      tick_q  <= 1'b0;
      y_q     <= '0;
      phase_q <= 1'b0;
`ifdef LED_BOUNCE_EN
      dir_q   <= 1'b0;
`endif
    end else begin
      mode_q  <= mode_s_q;
      cnt_q   <= cnt_d;
      tick_q  <= (cnt_d == CNT_LAST);
      y_q     <= y_d;
      phase_q <= phase_d;
`ifdef LED_BOUNCE_EN
      dir_q   <= dir_d;
`endif
    end
  end

  assign tick_out = tick_q;
  assign y_out    = y_q;

endmodule

// File: tb/tb_led_pattern_mux.sv
// Self-checking bench for led_pattern_mux (TICK_DIV=4, WIDTH=8): directed scenarios plus
// randomized traffic compared against a cycle-level reference model of the pattern rules.
module tb_led_pattern_mux;

  localparam int TD = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] sw_in = 8'h00;
  logic [1:0] mode_in = 2'd0;
  logic       tick_out;
  logic [7:0] y_out;

  int errors = 0;
  int checks = 0;

  // reference model state
  int m_sw_a, m_sw_s, m_md_a, m_md_s, m_mode, m_cnt, m_y, m_idx;
  bit m_ph;

  led_pattern_mux #(.TICK_DIV(TD), .WIDTH(8)) dut (
    .clk_in   (clk),
    .rst_n_in (rst_n),
    .sw_in    (sw_in),
    .mode_in  (mode_in),
    .tick_out (tick_out),
    .y_out    (y_out)
  );

  always #5 clk = ~clk;

  function automatic int chase_value(input int idx);
    int p;
`ifdef LED_BOUNCE_EN
    p = idx % 14;
    return (p <= 7) ? (1 << p) : (1 << (14 - p));
`else
    p = idx % 8;
    return 1 << p;
`endif
  endfunction

  task automatic model_reset();
    m_sw_a = 0; m_sw_s = 0; m_md_a = 0; m_md_s = 0;
    m_mode = 0; m_cnt = 0; m_y = 0; m_idx = 0; m_ph = 1'b0;
  endtask

  task automatic model_edge();
    bit fire;
    bit nph;
    int ny;
    int ncnt;
    fire = (m_cnt == TD - 1);
    ncnt = (m_cnt + 1) % TD;
    ny   = m_y;
    nph  = m_ph;
    if (m_md_s != m_mode) begin
      ncnt = 0;
      case (m_md_s)
        0:       ny = m_sw_s;
        1:       begin m_idx = 0; ny = 1; end
        2:       ny = 0;
        default: begin ny = m_sw_s; nph = 1'b1; end
      endcase
    end else begin
      case (m_mode)
        0:       ny = m_sw_s;
        1:       if (fire) begin m_idx = m_idx + 1; ny = chase_value(m_idx); end
        2:       if (fire) ny = (m_y + 1) % 256;
        default: begin
          if (fire) nph = !nph;
          ny = nph ? m_sw_s : 0;
        end
      endcase
    end
    m_y    = ny;
    m_cnt  = ncnt;
    m_ph   = nph;
    m_mode = m_md_s;
    m_md_s = m_md_a;
    m_md_a = int'(mode_in);
    m_sw_s = m_sw_a;
    m_sw_a = int'(sw_in);
  endtask

  task automatic tick_edge();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic wait_tick(input string tag);
    int n;
    n = 0;
    while (tick_out !== 1'b1 && n < 8) begin
      tick_edge();
      n++;
    end
    if (tick_out !== 1'b1) begin
      checks++; errors++;
      $display("FAIL %s_wait: tick_out got %b expected 1 within 8 cycles", tag, tick_out);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    for (int i = 0; i < 5; i++) begin
      sw_in   = 8'($urandom);
      mode_in = 2'($urandom);
      @(negedge clk);
      checks++;
      if (y_out !== 8'h00) begin errors++; $display("FAIL reset_y: got %h expected 00", y_out); end
      checks++;
      if (tick_out !== 1'b0) begin errors++; $display("FAIL reset_tick: got %b expected 0", tick_out); end
    end
    sw_in = 8'hA5; mode_in = 2'd0;
    @(negedge clk);
    rst_n = 1'b1;
    tick_edge();
    tick_edge();
    checks++;
    if (y_out !== 8'h00) begin errors++; $display("FAIL reset_latency2: got %h expected 00", y_out); end
    tick_edge();
    checks++;
    if (y_out !== 8'hA5) begin errors++; $display("FAIL reset_latency3: got %h expected a5", y_out); end
  endtask

  task automatic test_prescaler();
    bit exp_t;
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick_edge();
      exp_t = (k % 4 == 3);
      checks++;
      if (tick_out !== exp_t) begin
        errors++;
        $display("FAIL prescaler_cycle%0d: got %b expected %b", k, tick_out, exp_t);
      end
    end
  endtask

  task automatic test_chase();
    int exp_y;
    mode_in = 2'd1;
    repeat (3) tick_edge();
    checks++;
    if (y_out !== 8'h01) begin errors++; $display("FAIL chase_init: got %h expected 01", y_out); end
    for (int k = 0; k < 9; k++) begin
      wait_tick("chase");
      tick_edge();
      exp_y = chase_value(k + 1);
      checks++;
      if (y_out !== 8'(exp_y)) begin
        errors++;
        $display("FAIL chase_step%0d: got %h expected %h", k, y_out, 8'(exp_y));
      end
    end
  endtask

  task automatic test_count();
    mode_in = 2'd2;
    repeat (3) tick_edge();
    checks++;
    if (y_out !== 8'h00) begin errors++; $display("FAIL count_init: got %h expected 00", y_out); end
    for (int k = 0; k < 256; k++) begin
      wait_tick("count");
      tick_edge();
      checks++;
      if (y_out !== 8'((k + 1) % 256)) begin
        errors++;
        $display("FAIL count_step%0d: got %h expected %h", k, y_out, 8'((k + 1) % 256));
      end
    end
  endtask

  task automatic test_blink();
    logic [7:0] exp_seq [4];
    exp_seq[0] = 8'h00; exp_seq[1] = 8'h3C; exp_seq[2] = 8'h00; exp_seq[3] = 8'h3C;
    sw_in = 8'h3C; mode_in = 2'd3;
    repeat (3) tick_edge();
    checks++;
    if (y_out !== 8'h3C) begin errors++; $display("FAIL blink_init: got %h expected 3c", y_out); end
    for (int k = 0; k < 4; k++) begin
      wait_tick("blink");
      tick_edge();
      checks++;
      if (y_out !== exp_seq[k]) begin
        errors++;
        $display("FAIL blink_step%0d: got %h expected %h", k, y_out, exp_seq[k]);
      end
    end
    sw_in = 8'hFF;
    repeat (2) tick_edge();
    checks++;
    if (y_out !== 8'h3C) begin errors++; $display("FAIL blink_sw_edge2: got %h expected 3c", y_out); end
    tick_edge();
    checks++;
    if (y_out !== 8'hFF) begin errors++; $display("FAIL blink_sw_edge3: got %h expected ff", y_out); end
  endtask

  task automatic collide(input logic [1:0] new_mode, input logic [7:0] init_v, input string tag);
    int n;
    n = 0;
    while (m_cnt != 1 && n < 8) begin
      tick_edge();
      n++;
    end
    mode_in = new_mode;
    tick_edge();
    tick_edge();
    checks++;
    if (tick_out !== 1'b1) begin errors++; $display("FAIL %s_tick_before: got %b expected 1", tag, tick_out); end
    tick_edge();
    checks++;
    if (y_out !== init_v) begin errors++; $display("FAIL %s_init: got %h expected %h", tag, y_out, init_v); end
    for (int k = 1; k <= 3; k++) begin
      tick_edge();
      checks++;
      if (tick_out !== (k == 3)) begin
        errors++;
        $display("FAIL %s_restart%0d: tick got %b expected %b", tag, k, tick_out, (k == 3));
      end
    end
  endtask

  task automatic test_collision();
    int n;
    collide(2'd2, 8'h00, "collide_count");
    collide(2'd1, 8'h01, "collide_chase");
    mode_in = 2'd2;
    repeat (3) tick_edge();
    n = 0;
    while (y_out !== 8'h37 && n < 400) begin
      tick_edge();
      n++;
    end
    checks++;
    if (y_out !== 8'h37 || m_y != 8'h37) begin
      errors++;
      $display("FAIL midcount_reach: got %h expected 37 (model %h)", y_out, 8'(m_y));
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (y_out !== 8'h00) begin errors++; $display("FAIL async_reset_y: got %h expected 00", y_out); end
    checks++;
    if (tick_out !== 1'b0) begin errors++; $display("FAIL async_reset_tick: got %b expected 0", tick_out); end
    model_reset();
    @(negedge clk);
    mode_in = 2'd0;
    sw_in   = 8'h5A;
    rst_n   = 1'b1;
    tick_edge();
    checks++;
    if (y_out !== 8'h00) begin errors++; $display("FAIL post_reset_y: got %h expected 00", y_out); end
    repeat (2) tick_edge();
    checks++;
    if (y_out !== 8'h5A) begin errors++; $display("FAIL post_reset_pass: got %h expected 5a", y_out); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 11) == 0) mode_in = 2'($urandom);
      if ($urandom_range(0, 3) == 0) sw_in = 8'($urandom);
      tick_edge();
      checks++;
      if (y_out !== 8'(m_y)) begin
        errors++;
        $display("FAIL random_y%0d: got %h expected %h", i, y_out, 8'(m_y));
      end
      checks++;
      if (tick_out !== (m_cnt == TD - 1)) begin
        errors++;
        $display("FAIL random_tick%0d: got %b expected %b", i, tick_out, (m_cnt == TD - 1));
      end
    end
  endtask

  initial begin
    test_reset();
    test_prescaler();
    test_chase();
    test_count();
    test_blink();
    test_collision();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
